// File: rtl/ddr2_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// ddr2_cmd_arbiter
//
// Shares the MCB port-0 command interface between a write client (input-buffer
// drain) and a read client (output-buffer fill). One command is picked by
// round-robin, held stable in the p0_cmd_* registers, issued once the MCB
// command FIFO has room, and acknowledged with a one-cycle grant. Per-client
// issue counters and a sticky stall watchdog are provided for status readout.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   calib_done          MCB calibration complete, gates new arbitration
//   req_/instr_/addr_/bl_{wr,rd}   client command requests and fields
//   gnt_{wr,rd}         one-cycle pulse when the client's command is issued
//   p0_cmd_full         MCB command FIFO full (backpressure)
//   p0_cmd_en/instr/byte_addr/bl   registered MCB command strobe and fields
//   cnt_{wr,rd}         16-bit wrapping issue counters
//   stall_flag          sticky flag: STALL_LIMIT cycles stuck on a full FIFO
//   clear_stall         synchronous clear of stall_flag and the stall counter
// ----------------------------------------------------------------------------
module ddr2_cmd_arbiter #(
   parameter logic [9:0] STALL_LIMIT = 10'd1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        calib_done,
   input  logic        req_wr,
   input  logic [2:0]  instr_wr,
   input  logic [29:0] addr_wr,
   input  logic [5:0]  bl_wr,
   output logic        gnt_wr,
   input  logic        req_rd,
   input  logic [2:0]  instr_rd,
   input  logic [29:0] addr_rd,
   input  logic [5:0]  bl_rd,
   output logic        gnt_rd,
   input  logic        p0_cmd_full,
   output logic        p0_cmd_en,
   output logic [2:0]  p0_cmd_instr,
   output logic [29:0] p0_cmd_byte_addr,
   output logic [5:0]  p0_cmd_bl,
   output logic [15:0] cnt_wr,
   output logic [15:0] cnt_rd,
   output logic        stall_flag,
   input  logic        clear_stall
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
   typedef enum logic {SEL_WR = 1'b0, SEL_RD = 1'b1} sel_t;

   state_t      state_q, state_d;
   sel_t        sel_q, sel_d;
   sel_t        last_sel_q, last_sel_d;
   logic [2:0]  instr_q, instr_d;
   logic [29:0] addr_q, addr_d;
   logic [5:0]  bl_q, bl_d;
   logic        en_q, en_d;
   logic        gnt_wr_q, gnt_wr_d;
   logic        gnt_rd_q, gnt_rd_d;
   logic [15:0] cnt_wr_q, cnt_wr_d;
   logic [15:0] cnt_rd_q, cnt_rd_d;
   logic [9:0]  stall_cnt_q, stall_cnt_d;
   logic        stall_flag_q, stall_flag_d;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         sel_q        <= SEL_WR;
         last_sel_q   <= SEL_RD;   // wr wins the first tie after reset
         instr_q      <= '0;
         addr_q       <= '0;
         bl_q         <= '0;
         en_q         <= 1'b0;
         gnt_wr_q     <= 1'b0;
         gnt_rd_q     <= 1'b0;
         cnt_wr_q     <= '0;
         cnt_rd_q     <= '0;
         stall_cnt_q  <= '0;
         stall_flag_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_sel_q   <= last_sel_d;
         instr_q      <= instr_d;
         addr_q       <= addr_d;
         bl_q         <= bl_d;
         en_q         <= en_d;
         gnt_wr_q     <= gnt_wr_d;
         gnt_rd_q     <= gnt_rd_d;
         cnt_wr_q     <= cnt_wr_d;
         cnt_rd_q     <= cnt_rd_d;
         stall_cnt_q  <= stall_cnt_d;
         stall_flag_q <= stall_flag_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_sel_d   = last_sel_q;
      instr_d      = instr_q;
      addr_d       = addr_q;
      bl_d         = bl_q;
      en_d         = 1'b0;
      gnt_wr_d     = 1'b0;
      gnt_rd_d     = 1'b0;
      cnt_wr_d     = cnt_wr_q;
      cnt_rd_d     = cnt_rd_q;
      stall_cnt_d  = stall_cnt_q;
      stall_flag_d = stall_flag_q;

      case (state_q)
         S_IDLE: begin
            if (calib_done && (req_wr || req_rd)) begin
               // wr takes it when alone, or on a tie when rd went last
               if (req_wr && (!req_rd || last_sel_q == SEL_RD)) begin
                  sel_d   = SEL_WR;
                  instr_d = instr_wr;
                  addr_d  = addr_wr;
                  bl_d    = bl_wr;
               end else begin
                  sel_d   = SEL_RD;
                  instr_d = instr_rd;
                  addr_d  = addr_rd;
                  bl_d    = bl_rd;
               end
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!p0_cmd_full) begin
               en_d        = 1'b1;
               last_sel_d  = sel_q;
               stall_cnt_d = '0;
               state_d     = S_GAP;
               if (sel_q == SEL_WR) begin
                  gnt_wr_d = 1'b1;
                  cnt_wr_d = cnt_wr_q + 16'd1;
               end else begin
                  gnt_rd_d = 1'b1;
                  cnt_rd_d = cnt_rd_q + 16'd1;
               end
            end else begin
               if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 10'd1;
               if (stall_cnt_d >= STALL_LIMIT) stall_flag_d = 1'b1;
            end
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // clear has priority over a same-cycle set
      if (clear_stall) begin
         stall_flag_d = 1'b0;
         stall_cnt_d  = '0;
      end
   end

   assign p0_cmd_en        = en_q;
   assign p0_cmd_instr     = instr_q;
   assign p0_cmd_byte_addr = addr_q;
   assign p0_cmd_bl        = bl_q;
   assign gnt_wr           = gnt_wr_q;
   assign gnt_rd           = gnt_rd_q;
   assign cnt_wr           = cnt_wr_q;
   assign cnt_rd           = cnt_rd_q;
   assign stall_flag       = stall_flag_q;

endmodule
